// File: rtl/cache_ctrl_pkg.sv
// Shared encodings for the L1 controller: data-unit access widths, FSM states
// and small access-decode helpers.
package cache_ctrl_pkg;

    localparam logic [1:0] DU_W_LINE = 2'd0;
    localparam logic [1:0] DU_W_BYTE = 2'd1;
    localparam logic [1:0] DU_W_HALF = 2'd2;
    localparam logic [1:0] DU_W_WORD = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITE_THRU,
        S_REFILL,
        S_FILL
    } state_e;

    // Width 0 has no CPU meaning; halves and words must be naturally aligned.
    function automatic logic access_bad(input logic [1:0] width, input logic [1:0] lo);
        return (width == DU_W_LINE) ||
               (width == DU_W_HALF && lo[0]) ||
               (width == DU_W_WORD && lo != 2'b00);
    endfunction

    function automatic logic [3:0] byte_mask(input logic [1:0] width);
        case (width)
            DU_W_BYTE: return 4'b0001;
            DU_W_HALF: return 4'b0011;
            DU_W_WORD: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/cache_ctrl_tag_store.sv
// Tag array plus valid vector for the direct-mapped L1: registered read,
// single write port that marks the entry valid, one-cycle clear of all valids.
module cache_tag_store #(
    parameter int IDX_W = 4,
    parameter int TAG_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    output logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid
);

    logic [TAG_W-1:0]      tags [2**IDX_W];
    logic [2**IDX_W-1:0]   valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid    <= '0;
            rd_tag   <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (clear)
                valid <= '0;
            else if (wr_en)
                valid[wr_idx] <= 1'b1;
            // A write also lands in the read register so the replayed lookup sees the new line.
            if (wr_en) begin
                rd_tag   <= wr_tag;
                rd_valid <= 1'b1;
            end else if (rd_en) begin
                rd_tag   <= tags[rd_idx];
                rd_valid <= valid[rd_idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en)
            tags[wr_idx] <= wr_tag;
    end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 controller. Sequences an
// external cache_data_unit and refills missed lines word by word from memory.
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DU_ADDR_W = 8,
    parameter int LINE_BITS = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [XLEN-1:0]      cpu_addr_i,
    input  logic [1:0]           cpu_width_i,
    input  logic [XLEN-1:0]      cpu_wdata_i,
    output logic                 cpu_gnt_o,
    output logic                 cpu_rvalid_o,
    output logic [XLEN-1:0]      cpu_rdata_o,
    output logic                 cpu_err_o,
    input  logic                 flush_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [XLEN-1:0]      mem_addr_o,
    output logic [3:0]           mem_be_o,
    output logic [XLEN-1:0]      mem_wdata_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [XLEN-1:0]      mem_rdata_i,
    output logic                 du_we_o,
    output logic [DU_ADDR_W-1:0] du_addr_o,
    output logic [1:0]           du_width_o,
    output logic [LINE_BITS-1:0] du_wdata_o,
    input  logic [LINE_BITS-1:0] du_rdata_i
);

    localparam int IDX_W      = DU_ADDR_W - 4;
    localparam int TAG_W      = XLEN - DU_ADDR_W;
    localparam int LINE_WORDS = LINE_BITS / XLEN;
    localparam int CNT_W      = $clog2(LINE_WORDS);

    state_e                          state;
    logic                            req_we;
    logic [XLEN-1:0]                 req_addr;
    logic [1:0]                      req_width;
    logic [XLEN-1:0]                 req_wdata;
    logic [LINE_WORDS-1:0][XLEN-1:0] line_buf;
    logic [CNT_W-1:0]                word_cnt;
    logic                            rd_pend;
    logic                            replay;

    logic [TAG_W-1:0]     tag_q;
    logic                 valid_q;
    logic                 gnt, hit, bad;
    logic [LINE_BITS-1:0] line_shift;
    logic                 unused_du_hi;

    assign gnt = rst_ni && (state == S_IDLE) && cpu_req_i && !flush_i;
    assign bad = access_bad(req_width, req_addr[1:0]);
    assign hit = valid_q && (tag_q == req_addr[XLEN-1:DU_ADDR_W]);
    assign unused_du_hi = ^du_rdata_i[LINE_BITS-1:XLEN];

    cache_tag_store #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_tags (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear    ((state == S_IDLE) && flush_i),
        .rd_en    (gnt),
        .rd_idx   (cpu_addr_i[DU_ADDR_W-1:4]),
        .wr_en    (state == S_FILL),
        .wr_idx   (req_addr[DU_ADDR_W-1:4]),
        .wr_tag   (req_addr[XLEN-1:DU_ADDR_W]),
        .rd_tag   (tag_q),
        .rd_valid (valid_q)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= S_IDLE;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_width <= '0;
            req_wdata <= '0;
            line_buf  <= '0;
            word_cnt  <= '0;
            rd_pend   <= 1'b0;
            replay    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (gnt) begin
                    req_we    <= cpu_we_i;
                    req_addr  <= cpu_addr_i;
                    req_width <= cpu_width_i;
                    req_wdata <= cpu_wdata_i;
                    replay    <= 1'b0;
                    state     <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    if (bad)
                        state <= S_IDLE;
                    else if (req_we)
                        state <= S_WRITE_THRU;
                    else if (hit)
                        state <= S_IDLE;
                    else begin
                        word_cnt <= '0;
                        rd_pend  <= 1'b0;
                        state    <= S_REFILL;
                    end
                end
                S_WRITE_THRU: if (mem_gnt_i) state <= S_IDLE;
                S_REFILL: begin
                    // One read in flight: wait for its data before asking for the next word.
                    if (!rd_pend) begin
                        if (mem_gnt_i) rd_pend <= 1'b1;
                    end else if (mem_rvalid_i) begin
                        line_buf[word_cnt] <= mem_rdata_i;
                        rd_pend            <= 1'b0;
                        word_cnt           <= word_cnt + 1'b1;
                        if (word_cnt == CNT_W'(LINE_WORDS - 1))
                            state <= S_FILL;
                    end
                end
                S_FILL: begin
                    replay <= 1'b1;
                    state  <= S_LOOKUP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The data unit was being written during FILL, so the replayed load takes its data from the line buffer.
    assign line_shift = line_buf >> {req_addr[3:0], 3'b000};

    always_comb begin
        cpu_gnt_o    = gnt;
        cpu_rvalid_o = 1'b0;
        cpu_rdata_o  = '0;
        cpu_err_o    = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_be_o     = '0;
        mem_wdata_o  = '0;
        du_we_o      = 1'b0;
        du_addr_o    = '0;
        du_width_o   = DU_W_LINE;
        du_wdata_o   = '0;
        case (state)
            S_IDLE: du_addr_o = gnt ? cpu_addr_i[DU_ADDR_W-1:0] : '0;
            S_LOOKUP: begin
                du_addr_o = req_addr[DU_ADDR_W-1:0];
                if (bad) begin
                    cpu_rvalid_o = 1'b1;
                    cpu_err_o    = 1'b1;
                end else if (!req_we) begin
                    if (hit) begin
                        cpu_rvalid_o = 1'b1;
                        cpu_rdata_o  = replay ? line_shift[XLEN-1:0] : du_rdata_i[XLEN-1:0];
                    end
                end else if (hit) begin
                    du_we_o    = 1'b1;
                    du_width_o = req_width;
                    du_wdata_o = LINE_BITS'(req_wdata);
                end
            end
            S_WRITE_THRU: begin
                mem_req_o    = 1'b1;
                mem_we_o     = 1'b1;
                mem_addr_o   = {req_addr[XLEN-1:2], 2'b00};
                mem_be_o     = byte_mask(req_width) << req_addr[1:0];
                mem_wdata_o  = req_wdata << {req_addr[1:0], 3'b000};
                cpu_rvalid_o = mem_gnt_i;
            end
            S_REFILL: begin
                mem_req_o  = !rd_pend;
                mem_addr_o = {req_addr[XLEN-1:4], word_cnt, 2'b00};
            end
            S_FILL: begin
                du_we_o    = 1'b1;
                du_width_o = DU_W_LINE;
                du_addr_o  = {req_addr[DU_ADDR_W-1:4], 4'b0000};
                du_wdata_o = line_buf;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: models memory, the data unit and the CPU-visible
// semantics (flat memory + which lines are resident) and checks every response.
module tb_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_err, flush;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic [1:0]   cpu_width;
    logic         mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;
    logic [3:0]   mem_be;
    logic         du_we;
    logic [7:0]   du_addr;
    logic [1:0]   du_width;
    logic [127:0] du_wdata, du_rdata;

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_width_i(cpu_width),
        .cpu_wdata_i(cpu_wdata), .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid),
        .cpu_rdata_o(cpu_rdata), .cpu_err_o(cpu_err), .flush_i(flush),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .du_we_o(du_we), .du_addr_o(du_addr), .du_width_o(du_width),
        .du_wdata_o(du_wdata), .du_rdata_i(du_rdata)
    );

    int vectors = 0, errors = 0;
    int cyc = 0, resp_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory: physical (bus side) and reference (CPU semantics)
    logic [31:0] phys [logic [31:0]];
    logic [31:0] refm [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {16'hA5A5, a[15:0]};
    endfunction
    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys.exists(a) ? phys[a] : init_word(a);
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return refm.exists(a) ? refm[a] : init_word(a);
    endfunction
    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        w = ref_rd({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction
    task automatic ref_wr_byte(input logic [31:0] a, input logic [7:0] v);
        logic [31:0] w;
        w = ref_rd({a[31:2], 2'b00});
        w[8*a[1:0] +: 8] = v;
        refm[{a[31:2], 2'b00}] = w;
    endtask

    int          n_rd = 0, n_wr = 0, n_du = 0;
    logic [31:0] rd_log [$];
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_be;
    logic        rd_busy = 1'b0;
    int          rd_cnt = 0;
    logic [31:0] rd_addr;

    // Memory responder: random grant delay, 1..3 cycle read latency, drops reads on reset.
    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (!rst_n) begin
                rd_busy = 1'b0;
            end else if (rd_busy) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = phys_rd(rd_addr);
                    rd_busy    = 1'b0;
                end
            end else if (mem_req && $urandom_range(0, 2) != 0) begin
                mem_gnt = 1'b1;
                if (mem_we) begin
                    logic [31:0] w;
                    w = phys_rd(mem_addr);
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                    phys[mem_addr] = w;
                    n_wr++;
                    wr_addr = mem_addr; wr_be = mem_be; wr_data = mem_wdata;
                end else begin
                    n_rd++;
                    rd_log.push_back(mem_addr);
                    rd_busy = 1'b1;
                    rd_cnt  = $urandom_range(1, 3);
                    rd_addr = mem_addr;
                end
            end
        end
    end

    // ---------------- data unit: 16 x 128-bit lines, read-first, 1-cycle read latency
    logic [127:0] du_mem [16];
    logic [127:0] du_next = '0;
    logic [1:0]   du_last_w;
    logic [7:0]   du_last_a;

    initial begin
        forever begin
            @(negedge clk);
            du_next = du_mem[du_addr[7:4]] >> {du_addr[3:0], 3'b000};
            if (du_we) begin
                n_du++;
                du_last_w = du_width;
                du_last_a = du_addr;
                if (du_width == 2'd0)
                    du_mem[du_addr[7:4]] = du_wdata;
                else
                    for (int b = 0; b < (du_width == 2'd1 ? 1 : du_width == 2'd2 ? 2 : 4); b++)
                        if (int'(du_addr[3:0]) + b < 16)
                            du_mem[du_addr[7:4]][8*(int'(du_addr[3:0]) + b) +: 8] = du_wdata[8*b +: 8];
            end
        end
    end
    initial begin
        du_rdata = '0;
        forever begin
            @(posedge clk); #1;
            du_rdata = du_next;
        end
    end

    // ---------------- CPU-level reference: which lines are resident
    logic        present [16];
    logic [23:0] ptag [16];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  width;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nrd, nwr, ndu;
        logic [31:0] waddr, wdata;
        logic [3:0]  wbe;
        int          c_gnt, s_rd, s_wr, s_du;
    } exp_t;
    exp_t exp_q [$];

    task automatic predict(input logic we, input logic [31:0] a, input logic [1:0] w,
                           input logic [31:0] wd, output exp_t e);
        int  nb;
        logic hitm;
        e = '{default: 0};
        e.we = we; e.addr = a; e.width = w; e.lat = -1;
        nb = (w == 2'd1) ? 1 : (w == 2'd2) ? 2 : 4;
        hitm = present[a[7:4]] && ptag[a[7:4]] == a[31:8];
        if (w == 2'd0 || (w == 2'd2 && a[0]) || (w == 2'd3 && a[1:0] != 2'b00)) begin
            e.err = 1'b1; e.lat = 1;
        end else if (!we) begin
            for (int i = 0; i < 4; i++)
                e.rdata[8*i +: 8] = (int'(a[3:0]) + i < 16) ? ref_byte(a + 32'(i)) : 8'h00;
            if (hitm) e.lat = 1;
            else begin
                e.nrd = 4; e.ndu = 1;
                present[a[7:4]] = 1'b1; ptag[a[7:4]] = a[31:8];
            end
        end else begin
            e.nwr = 1; e.ndu = hitm ? 1 : 0;
            e.waddr = {a[31:2], 2'b00};
            e.wbe = 4'((nb == 4) ? 15 : (1 << nb) - 1) << a[1:0];
            e.wdata = wd << (8 * a[1:0]);
            for (int i = 0; i < nb; i++) ref_wr_byte(a + 32'(i), wd[8*i +: 8]);
        end
    endtask

    // ---------------- compare process: every CPU response against the model
    logic [31:0] last_rdata, last_rd0, last_rd3;
    int          last_lat, last_nrd;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #1;
            if (rst_n && cpu_rvalid) begin
                if (exp_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL spurious_rvalid: got rvalid=1 expected no response");
                end else begin
                    e = exp_q.pop_front();
                    last_lat = cyc - e.c_gnt; last_rdata = cpu_rdata; last_nrd = n_rd - e.s_rd;
                    last_rd0 = rd_log.size() > 0 ? rd_log[0] : 32'hX;
                    last_rd3 = rd_log.size() > 3 ? rd_log[3] : 32'hX;
                    chk("err", cpu_err, e.err);
                    if (e.lat >= 0) chk("latency", last_lat, e.lat);
                    chk("mem_reads", last_nrd, e.nrd);
                    chk("mem_writes", n_wr - e.s_wr, e.nwr);
                    chk("du_writes", n_du - e.s_du, e.ndu);
                    if (!e.err && !e.we) begin
                        chk("rdata", cpu_rdata, e.rdata);
                        if (e.nrd == 4) begin
                            for (int k = 0; k < 4; k++)
                                chk("refill_addr", rd_log.size() > k ? rd_log[k] : 32'hX,
                                    {e.addr[31:4], 4'h0} + 32'(4 * k));
                            chk("fill_du", {du_last_w, du_last_a}, {2'd0, e.addr[7:4], 4'h0});
                        end
                    end
                    if (!e.err && e.we) begin
                        chk("wr_addr", wr_addr, e.waddr);
                        chk("wr_be", wr_be, e.wbe);
                        chk("wr_data", wr_data, e.wdata);
                        if (e.ndu == 1) chk("store_du", {du_last_w, du_last_a}, {e.width, e.addr[7:0]});
                    end
                    resp_cnt++;
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] a, input logic [1:0] w,
                         input logic [31:0] wd, input bit wait_resp);
        exp_t e;
        int   n0, t;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_width = w; cpu_wdata = wd;
        @(negedge clk); #1;
        chk("gnt", cpu_gnt, 1'b1);
        predict(we, a, w, wd, e);
        e.c_gnt = cyc; e.s_rd = n_rd; e.s_wr = n_wr; e.s_du = n_du;
        rd_log.delete();
        n0 = resp_cnt;
        exp_q.push_back(e);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_wdata = $urandom;
        if (wait_resp) begin
            t = 0;
            while (resp_cnt == n0 && t < 300) begin
                @(negedge clk); #2;
                t++;
            end
            if (resp_cnt == n0) begin
                vectors++; errors++;
                $display("FAIL timeout: got no response for addr %0h expected one within 300 cycles", a);
                exp_q.delete();
            end
        end
    endtask

    task automatic do_flush(input bit with_req);
        @(posedge clk); #1;
        flush = 1'b1; cpu_req = with_req; cpu_we = 1'b0; cpu_addr = 32'h100; cpu_width = 2'd3;
        @(negedge clk); #1;
        chk("flush_gnt", cpu_gnt, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; cpu_req = 1'b0;
        for (int i = 0; i < 16; i++) present[i] = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        chk(name, {cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err, mem_req, mem_we, mem_addr,
                   mem_be, mem_wdata, du_we, du_addr, du_width}, '0);
        chk({name, "_du_wdata"}, du_wdata, '0);
    endtask

    initial begin
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_width = 0; cpu_wdata = 0; flush = 0;
        for (int i = 0; i < 16; i++) begin
            du_mem[i] = {$urandom, $urandom, $urandom, $urandom};
            present[i] = 1'b0; ptag[i] = '0;
        end
        repeat (3) @(negedge clk);
        #1 check_idle_outputs("reset_outputs");
        @(negedge clk); rst_n = 1'b1;

        // cold miss, then hit on the same line
        issue(0, 32'h100, 2'd3, 0, 1);
        chk("t1_rdata", last_rdata, 32'hA5A50100);
        chk("t1_nrd", last_nrd, 4);
        chk("t1_rd0", last_rd0, 32'h100);
        chk("t1_rd3", last_rd3, 32'h10C);
        issue(0, 32'h104, 2'd3, 0, 1);
        chk("t2_rdata", last_rdata, 32'hA5A50104);
        chk("t2_lat", last_lat, 1);
        chk("t2_nrd", last_nrd, 0);
        // byte store hit, then read it back
        issue(1, 32'h105, 2'd1, 32'h000000AB, 1);
        chk("t3_be", wr_be, 4'b0010);
        chk("t3_wdata", wr_data, 32'h0000AB00);
        chk("t3_du_w", du_last_w, 2'd1);
        issue(0, 32'h104, 2'd3, 0, 1);
        chk("t3_rdata", last_rdata, 32'hA5A5AB04);
        // store miss does not allocate
        issue(1, 32'h200, 2'd3, 32'hDEADBEEF, 1);
        issue(0, 32'h200, 2'd3, 0, 1);
        chk("t4_nrd", last_nrd, 4);
        chk("t4_rdata", last_rdata, 32'hDEADBEEF);
        // misaligned half
        issue(0, 32'h101, 2'd2, 0, 1);
        chk("t5_lat", last_lat, 1);
        chk("t5_nrd", last_nrd, 0);
        // flush forces a refill of a resident line
        issue(0, 32'h100, 2'd3, 0, 1);
        issue(0, 32'h100, 2'd3, 0, 1);
        chk("t6_hit_nrd", last_nrd, 0);
        do_flush(1);
        issue(0, 32'h100, 2'd3, 0, 1);
        chk("t6_nrd", last_nrd, 4);
        chk("t6_rdata", last_rdata, 32'hA5A50100);
        // reset in the middle of a refill
        issue(0, 32'h110, 2'd3, 0, 1);
        issue(0, 32'h300, 2'd3, 0, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk); #1;
        check_idle_outputs("midreset_outputs");
        exp_q.delete();
        for (int i = 0; i < 16; i++) present[i] = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        issue(0, 32'h110, 2'd3, 0, 1);
        chk("t7_nrd", last_nrd, 4);

        // randomized traffic over four tags sharing the sixteen sets
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 99) < 4) do_flush(1'($urandom_range(0, 1)));
            else begin
                logic [31:0] a;
                logic [1:0]  w;
                a = 32'($urandom_range(0, 32'h3FF));
                w = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 3) != 0) begin
                    if (w == 2'd2) a[0] = 1'b0;
                    if (w == 2'd3) a[1:0] = 2'b00;
                end
                issue(1'($urandom_range(0, 2) == 0), a, w, $urandom, 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
